ser2par_packer: RTL and testbench



---
 rtl/ser2par_packer.sv | 87 ++++++++
 tb/tb_ser2par_packer.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/ser2par_packer.sv
// Serial-to-parallel packer: gathers PARWIDTH/SERWIDTH narrow beats into one wide
// word, with early termination via ser_last reported through per-lane keep flags.
module ser2par_packer #(
  parameter int SERWIDTH   = 8,
  parameter int PARWIDTH   = 32,
  parameter bit DATA_ORDER = 1'b1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         ser_valid,
  output logic                         ser_ready,
  input  logic [SERWIDTH-1:0]          ser_din,
  input  logic                         ser_last,
  output logic                         par_valid,
  input  logic                         par_ready,
  output logic [PARWIDTH-1:0]          par_dout,
  output logic [PARWIDTH/SERWIDTH-1:0] par_keep,
  output logic                         par_last
);

  localparam int RATIO = PARWIDTH / SERWIDTH;
  localparam int CW    = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(RATIO - 1);

  // Handshake: a beat moves on ser_valid & ser_ready, a word on par_valid & par_ready;
  // ser_ready only drops while an undrained word sits on the output.
  logic                ser_acc;
  logic                par_acc;
  logic                complete;
  logic [CW-1:0]       beat_cnt;
  logic [CW-1:0]       lane;
  logic [PARWIDTH-1:0] acc_data;
  logic [RATIO-1:0]    acc_keep;
  logic [PARWIDTH-1:0] beat_data;
  logic [RATIO-1:0]    beat_keep;

  assign ser_ready = !par_valid || par_ready;
  assign ser_acc   = ser_valid && ser_ready;
  assign par_acc   = par_valid && par_ready;
  assign complete  = ser_acc && ((beat_cnt == LAST_CNT) || ser_last);

  always_comb begin
    lane      = DATA_ORDER ? beat_cnt : (LAST_CNT - beat_cnt);
    beat_data = '0;
    beat_keep = '0;
    for (int i = 0; i < RATIO; i++) begin
      if (lane == CW'(i)) begin
        beat_data[i*SERWIDTH +: SERWIDTH] = ser_din;
        beat_keep[i]                      = 1'b1;
      end
    end
  end

  // Accumulator: the completing beat bypasses it straight into the output word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_data <= '0;
      acc_keep <= '0;
      beat_cnt <= '0;
    end else if (complete) begin
      acc_data <= '0;
      acc_keep <= '0;
      beat_cnt <= '0;
    end else if (ser_acc) begin
      acc_data <= acc_data | beat_data;
      acc_keep <= acc_keep | beat_keep;
      beat_cnt <= beat_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      par_valid <= 1'b0;
      par_dout  <= '0;
      par_keep  <= '0;
      par_last  <= 1'b0;
    end else if (complete) begin
      par_valid <= 1'b1;
      par_dout  <= acc_data | beat_data;
      par_keep  <= acc_keep | beat_keep;
      par_last  <= ser_last;
    end else if (par_acc) begin
      par_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ser2par_packer.sv
// Directed bench for ser2par_packer: both lane orders side by side, a vector table
// for the main stream, then hand sequences for back-pressure and mid-word reset.
module tb_ser2par_packer;

  logic       clk;
  logic       rst_n;
  logic       ser_valid;
  logic [7:0] ser_din;
  logic       ser_last;
  logic       par_ready;

  logic        a_ser_ready, b_ser_ready;
  logic        a_par_valid, b_par_valid;
  logic [31:0] a_par_dout,  b_par_dout;
  logic [3:0]  a_par_keep,  b_par_keep;
  logic        a_par_last,  b_par_last;

  int errors = 0;
  int checks = 0;
  logic [31:0] exp_q[$];

  ser2par_packer #(.SERWIDTH(8), .PARWIDTH(32), .DATA_ORDER(1'b1)) dut_lsb (
    .clk(clk), .rst_n(rst_n),
    .ser_valid(ser_valid), .ser_ready(a_ser_ready), .ser_din(ser_din), .ser_last(ser_last),
    .par_valid(a_par_valid), .par_ready(par_ready), .par_dout(a_par_dout),
    .par_keep(a_par_keep), .par_last(a_par_last)
  );

  ser2par_packer #(.SERWIDTH(8), .PARWIDTH(32), .DATA_ORDER(1'b0)) dut_msb (
    .clk(clk), .rst_n(rst_n),
    .ser_valid(ser_valid), .ser_ready(b_ser_ready), .ser_din(ser_din), .ser_last(ser_last),
    .par_valid(b_par_valid), .par_ready(par_ready), .par_dout(b_par_dout),
    .par_keep(b_par_keep), .par_last(b_par_last)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        v;
    logic [7:0]  d;
    logic        l;
    logic        pr;
    logic        rdy;
    logic        pv;
    logic [31:0] dout1;
    logic [31:0] dout0;
    logic [3:0]  keep1;
    logic [3:0]  keep0;
    logic        last;
  } vec_t;

  vec_t vecs[19];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [7:0] d, input logic l, input logic pr);
    ser_valid = v;
    ser_din   = d;
    ser_last  = l;
    par_ready = pr;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: every word the LSB-order instance hands over is compared in order.
  always @(negedge clk) begin
    if (rst_n && a_par_valid && par_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_unexpected: got %h expected none", a_par_dout);
      end else begin
        chk("sb_word", a_par_dout, exp_q.pop_front());
      end
    end
  end

  initial begin
    vecs[0]  = '{1'b1, 8'h11, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 32'h0, 4'h0, 4'h0, 1'b0};
    vecs[1]  = '{1'b1, 8'h22, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 32'h0, 4'h0, 4'h0, 1'b0};
    vecs[2]  = '{1'b1, 8'h33, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 32'h0, 4'h0, 4'h0, 1'b0};
    vecs[3]  = '{1'b1, 8'h44, 1'b0, 1'b1, 1'b1, 1'b1, 32'h44332211, 32'h11223344, 4'hF, 4'hF, 1'b0};
    vecs[4]  = '{1'b1, 8'hAA, 1'b0, 1'b1, 1'b1, 1'b0, 32'h44332211, 32'h11223344, 4'hF, 4'hF, 1'b0};
    vecs[5]  = '{1'b1, 8'hBB, 1'b1, 1'b1, 1'b1, 1'b1, 32'h0000BBAA, 32'hAABB0000, 4'h3, 4'hC, 1'b1};
    vecs[6]  = '{1'b1, 8'hCC, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0000BBAA, 32'hAABB0000, 4'h3, 4'hC, 1'b1};
    vecs[7]  = '{1'b1, 8'hDD, 1'b1, 1'b1, 1'b1, 1'b1, 32'h0000DDCC, 32'hCCDD0000, 4'h3, 4'hC, 1'b1};
    vecs[8]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0000DDCC, 32'hCCDD0000, 4'h3, 4'hC, 1'b1};
    vecs[9]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0000DDCC, 32'hCCDD0000, 4'h3, 4'hC, 1'b1};
    vecs[10] = '{1'b1, 8'h01, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0000DDCC, 32'hCCDD0000, 4'h3, 4'hC, 1'b1};
    vecs[11] = '{1'b1, 8'h02, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0000DDCC, 32'hCCDD0000, 4'h3, 4'hC, 1'b1};
    vecs[12] = '{1'b1, 8'h03, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0000DDCC, 32'hCCDD0000, 4'h3, 4'hC, 1'b1};
    vecs[13] = '{1'b1, 8'h04, 1'b0, 1'b1, 1'b1, 1'b1, 32'h04030201, 32'h01020304, 4'hF, 4'hF, 1'b0};
    vecs[14] = '{1'b1, 8'h05, 1'b0, 1'b1, 1'b1, 1'b0, 32'h04030201, 32'h01020304, 4'hF, 4'hF, 1'b0};
    vecs[15] = '{1'b1, 8'h06, 1'b0, 1'b1, 1'b1, 1'b0, 32'h04030201, 32'h01020304, 4'hF, 4'hF, 1'b0};
    vecs[16] = '{1'b1, 8'h07, 1'b0, 1'b1, 1'b1, 1'b0, 32'h04030201, 32'h01020304, 4'hF, 4'hF, 1'b0};
    vecs[17] = '{1'b1, 8'h08, 1'b0, 1'b1, 1'b1, 1'b1, 32'h08070605, 32'h05060708, 4'hF, 4'hF, 1'b0};
    vecs[18] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 32'h08070605, 32'h05060708, 4'hF, 4'hF, 1'b0};

    exp_q.push_back(32'h44332211);
    exp_q.push_back(32'h0000BBAA);
    exp_q.push_back(32'h0000DDCC);
    exp_q.push_back(32'h04030201);
    exp_q.push_back(32'h08070605);
    exp_q.push_back(32'h14131211);
    exp_q.push_back(32'h00000021);
    exp_q.push_back(32'h88776655);

    // Reset values
    rst_n = 1'b0;
    drive(1'b0, 8'h00, 1'b0, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_par_valid", {31'b0, a_par_valid}, 32'h0);
    chk("rst_par_dout",  a_par_dout, 32'h0);
    chk("rst_par_keep",  {28'b0, a_par_keep}, 32'h0);
    chk("rst_par_last",  {31'b0, a_par_last}, 32'h0);
    chk("rst_ser_ready", {31'b0, a_ser_ready}, 32'h1);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // Table-driven stream: both lane orders, early termination, drain timing
    for (int i = 0; i < 19; i++) begin
      drive(vecs[i].v, vecs[i].d, vecs[i].l, vecs[i].pr);
      #1;
      chk($sformatf("v%0d_ser_ready", i), {31'b0, a_ser_ready}, {31'b0, vecs[i].rdy});
      chk($sformatf("v%0d_ser_ready_msb", i), {31'b0, b_ser_ready}, {31'b0, vecs[i].rdy});
      step();
      chk($sformatf("v%0d_par_valid", i), {31'b0, a_par_valid}, {31'b0, vecs[i].pv});
      chk($sformatf("v%0d_par_valid_msb", i), {31'b0, b_par_valid}, {31'b0, vecs[i].pv});
      chk($sformatf("v%0d_dout_lsb", i), a_par_dout, vecs[i].dout1);
      chk($sformatf("v%0d_dout_msb", i), b_par_dout, vecs[i].dout0);
      chk($sformatf("v%0d_keep_lsb", i), {28'b0, a_par_keep}, {28'b0, vecs[i].keep1});
      chk($sformatf("v%0d_keep_msb", i), {28'b0, b_par_keep}, {28'b0, vecs[i].keep0});
      chk($sformatf("v%0d_last", i), {31'b0, a_par_last}, {31'b0, vecs[i].last});
    end

    // Back-pressure: hold a full word for 10 cycles with a beat waiting
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 8'h11 + 8'(i), 1'b0, 1'b0);
      step();
    end
    chk("bp_full_valid", {31'b0, a_par_valid}, 32'h1);
    drive(1'b1, 8'h21, 1'b1, 1'b0);
    for (int i = 0; i < 10; i++) begin
      #1;
      chk($sformatf("bp%0d_ser_ready", i), {31'b0, a_ser_ready}, 32'h0);
      step();
      chk($sformatf("bp%0d_valid", i), {31'b0, a_par_valid}, 32'h1);
      chk($sformatf("bp%0d_dout", i), a_par_dout, 32'h14131211);
      chk($sformatf("bp%0d_keep", i), {28'b0, a_par_keep}, 32'hF);
    end
    // Drain and a completing ser_last beat in the same cycle
    par_ready = 1'b1;
    #1;
    chk("bp_release_ser_ready", {31'b0, a_ser_ready}, 32'h1);
    step();
    chk("bp_b2b_valid", {31'b0, a_par_valid}, 32'h1);
    chk("bp_b2b_dout_lsb", a_par_dout, 32'h00000021);
    chk("bp_b2b_dout_msb", b_par_dout, 32'h21000000);
    chk("bp_b2b_keep_lsb", {28'b0, a_par_keep}, 32'h1);
    chk("bp_b2b_keep_msb", {28'b0, b_par_keep}, 32'h8);
    chk("bp_b2b_last", {31'b0, a_par_last}, 32'h1);
    drive(1'b0, 8'h00, 1'b0, 1'b1);
    step();
    chk("bp_drained_valid", {31'b0, a_par_valid}, 32'h0);

    // Asynchronous reset mid-word discards the partial word
    drive(1'b1, 8'hE1, 1'b0, 1'b1);
    step();
    drive(1'b1, 8'hE2, 1'b0, 1'b1);
    step();
    drive(1'b0, 8'h00, 1'b0, 1'b1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("mrst_par_valid", {31'b0, a_par_valid}, 32'h0);
    chk("mrst_par_dout",  a_par_dout, 32'h0);
    chk("mrst_par_keep",  {28'b0, a_par_keep}, 32'h0);
    chk("mrst_par_last",  {31'b0, a_par_last}, 32'h0);
    chk("mrst_ser_ready", {31'b0, a_ser_ready}, 32'h1);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 8'h55 + 8'(i * 8'h11), 1'b0, 1'b1);
      step();
      chk($sformatf("mrst_b%0d_valid", i), {31'b0, a_par_valid}, (i == 3) ? 32'h1 : 32'h0);
    end
    chk("mrst_dout_lsb", a_par_dout, 32'h88776655);
    chk("mrst_dout_msb", b_par_dout, 32'h55667788);
    chk("mrst_keep", {28'b0, a_par_keep}, 32'hF);
    chk("mrst_last", {31'b0, a_par_last}, 32'h0);
    drive(1'b0, 8'h00, 1'b0, 1'b1);
    step();
    step();

    chk("sb_queue_empty", exp_q.size(), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
